fpu_insn_decoder: RTL and testbench

Accepts raw RV32 Zhinx instruction words with their integer-register operand values, decodes them into an FPU operation and resolved rounding mode, and buffers the result in a small FIFO toward the FPU execute stage. It holds the dynamic rounding-mode register (`frm`) and flags every illegal encoding instead of dropping it. It sits between the core's issue stage and the half-precision FPU datapath.

---
 rtl/fpu_types_pkg.sv | 77 +++++++
 rtl/fpu_dec_fifo.sv | 53 +++++
 rtl/fpu_insn_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_fpu_insn_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_types_pkg.sv
// ---------------------------------------------------------------------------
// fpu_types_pkg
// Shared types and constants for the half-precision (Zhinx) FPU front end:
//   - rv32zhinx_insn_t : field layout of an RV32 OP-FP / R4 instruction word
//   - fpu_operation_t  : 4-bit FPU operation code (0 = none / illegal)
//   - fpu_dec_entry_t  : one decoded entry as queued toward the execute stage
//   - rounding-mode, format, opcode and funct5 constants
// ---------------------------------------------------------------------------
package fpu_types_pkg;

   typedef struct packed {
      logic [4:0] funct5;   // rs3 index for the R4 (fused) forms
      logic [1:0] fmt;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] rm;
      logic [4:0] rd;
      logic [6:0] opcode;
   } rv32zhinx_insn_t;

   typedef enum logic [3:0] {
      OP_NONE   = 4'd0,
      OP_ADD    = 4'd1,
      OP_SUB    = 4'd2,
      OP_MUL    = 4'd3,
      OP_DIV    = 4'd4,
      OP_SQRT   = 4'd5,
      OP_SGNJ   = 4'd6,
      OP_MINMAX = 4'd7,
      OP_CMP    = 4'd8,
      OP_CLASS  = 4'd9,
      OP_MADD   = 4'd10,
      OP_MSUB   = 4'd11,
      OP_NMADD  = 4'd12,
      OP_NMSUB  = 4'd13
   } fpu_operation_t;

   typedef struct packed {
      fpu_operation_t op;
      logic [2:0]     sub;
      logic [2:0]     rm;
      logic [15:0]    a;
      logic [15:0]    b;
      logic [15:0]    c;
      logic [4:0]     rd;
      logic           illegal;
   } fpu_dec_entry_t;

   localparam int FPU_DEC_ENTRY_W = $bits(fpu_dec_entry_t);

   // MIN/MAX selection carried in the rm field
   localparam logic [2:0] RM_FMIN   = 3'b000;
   localparam logic [2:0] RM_FMAX   = 3'b001;
   // Reserved static rounding modes and the "use frm" selector
   localparam logic [2:0] RM_RSVD_5 = 3'b101;
   localparam logic [2:0] RM_RSVD_6 = 3'b110;
   localparam logic [2:0] RM_DYN    = 3'b111;

   localparam logic [1:0] FMT_H = 2'b10;

   localparam logic [6:0] OPC_OPFP   = 7'b1010011;
   localparam logic [6:0] OPC_FMADD  = 7'b1000011;
   localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
   localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
   localparam logic [6:0] OPC_FNMADD = 7'b1001111;

   localparam logic [4:0] F5_ADD    = 5'b00000;
   localparam logic [4:0] F5_SUB    = 5'b00001;
   localparam logic [4:0] F5_MUL    = 5'b00010;
   localparam logic [4:0] F5_DIV    = 5'b00011;
   localparam logic [4:0] F5_SQRT   = 5'b01011;
   localparam logic [4:0] F5_SGNJ   = 5'b00100;
   localparam logic [4:0] F5_MINMAX = 5'b00101;
   localparam logic [4:0] F5_CMP    = 5'b10100;
   localparam logic [4:0] F5_CLASS  = 5'b11100;

endpackage

// File: rtl/fpu_dec_fifo.sv
// ---------------------------------------------------------------------------
// fpu_dec_fifo
// Small synchronous FIFO holding decoded FPU entries.
// Ports:
//   CLK, RST         : clock, synchronous active-high reset (pointers only)
//   push, push_data  : write one entry (caller guarantees !full)
//   pop              : drop the head entry (caller guarantees !empty)
//   head             : current head entry (contents undefined while empty)
//   empty, full      : occupancy status, both derived from registered pointers
// Pointers carry one extra MSB so full and empty are told apart without a
// separate counter. Storage is not reset; only the pointers are.
// ---------------------------------------------------------------------------
module fpu_dec_fifo
#(
   parameter int DEPTH = 2
) (
   input  logic                                      CLK,
   input  logic                                      RST,
   input  logic                                      push,
   input  logic [fpu_types_pkg::FPU_DEC_ENTRY_W-1:0] push_data,
   input  logic                                      pop,
   output logic [fpu_types_pkg::FPU_DEC_ENTRY_W-1:0] head,
   output logic                                      empty,
   output logic                                      full
);
   import fpu_types_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]                wptr;
   logic [AW:0]                rptr;
   logic [FPU_DEC_ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wptr[AW-1:0]] <= push_data;
   end

   assign head  = mem[rptr[AW-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/fpu_insn_decoder.sv
// ---------------------------------------------------------------------------
// fpu_insn_decoder
// Decodes RV32 Zhinx instruction words (with their integer-register operand
// values) into an FPU operation plus a resolved static rounding mode, and
// queues the result toward the half-precision FPU execute stage. Illegal
// encodings are queued too, flagged with out_illegal.
//
// Ports:
//   CLK, RST                        : clock, synchronous active-high reset
//   in_valid / in_ready             : instruction handshake (in_ready is the
//                                     registered not-full status, low in reset)
//   in_insn                         : instruction word
//   in_rs1_val/in_rs2_val/in_rs3_val: register operand values (low 16 used)
//   frm_we, frm_wdata, frm          : dynamic rounding-mode register
//   out_valid / out_ready           : head-of-queue handshake
//   out_op, out_sub, out_rm         : operation, sub-op, resolved rounding mode
//   out_a, out_b, out_c             : half-precision operands
//   out_rd, out_illegal             : destination register, illegal flag
//
// Build option: define FPU_DECODE_FUSED_EN to decode the four R4 fused
// multiply-add opcodes and carry rs3 on out_c. Without it those opcodes are
// illegal and out_c is always 0.
// ---------------------------------------------------------------------------
module fpu_insn_decoder
#(
   parameter int DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_insn,
   input  logic [31:0] in_rs1_val,
   input  logic [31:0] in_rs2_val,
   input  logic [31:0] in_rs3_val,
   input  logic        frm_we,
   input  logic [2:0]  frm_wdata,
   output logic [2:0]  frm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_op,
   output logic [2:0]  out_sub,
   output logic [2:0]  out_rm,
   output logic [15:0] out_a,
   output logic [15:0] out_b,
   output logic [15:0] out_c,
   output logic [4:0]  out_rd,
   output logic        out_illegal
);
   import fpu_types_pkg::*;

   // Returns {unusable, effective_rm}. rm 111 selects the dynamic mode; the
   // effective mode must then be one of the five defined static modes.
   function automatic logic [3:0] resolve_rm(input logic [2:0] rm,
                                             input logic [2:0] dyn);
      logic [2:0] eff;
      eff = (rm == RM_DYN) ? dyn : rm;
      return {(eff == RM_RSVD_5) || (eff == RM_RSVD_6) || (eff == RM_DYN), eff};
   endfunction

   rv32zhinx_insn_t            insn;
   logic [2:0]                 frm_q;
   fpu_operation_t             op_p0;
   logic [2:0]                 sub_p0;
   logic                       rounds_p0;
   logic                       ok_p0;
   logic                       legal_p0;
   logic [3:0]                 rm_res_p0;
   fpu_dec_entry_t             dec_p0;
   logic                       vld_p0;
   logic [FPU_DEC_ENTRY_W-1:0] head_bits_p1;
   fpu_dec_entry_t             head_p1;
   logic                       vld_p1;
   logic                       fifo_empty;
   logic                       fifo_full;
   logic                       pop;
   logic                       unused_bits;

   assign insn = in_insn;

   // Dynamic rounding mode: a write takes effect for the next cycle's decode.
   always_ff @(posedge CLK) begin
      if (RST) begin
         frm_q <= 3'b000;
      end else if (frm_we) begin
         frm_q <= frm_wdata;
      end
   end

   assign frm = frm_q;

   // ---- stage p0: combinational decode of the offered instruction ----
   always_comb begin
      op_p0     = OP_NONE;
      sub_p0    = 3'b000;
      rounds_p0 = 1'b0;
      ok_p0     = 1'b0;
      rm_res_p0 = resolve_rm(insn.rm, frm_q);

      case (insn.opcode)
         OPC_OPFP: begin
            case (insn.funct5)
               F5_ADD:    begin op_p0 = OP_ADD; rounds_p0 = 1'b1; ok_p0 = 1'b1; end
               F5_SUB:    begin op_p0 = OP_SUB; rounds_p0 = 1'b1; ok_p0 = 1'b1; end
               F5_MUL:    begin op_p0 = OP_MUL; rounds_p0 = 1'b1; ok_p0 = 1'b1; end
               F5_DIV:    begin op_p0 = OP_DIV; rounds_p0 = 1'b1; ok_p0 = 1'b1; end
               F5_SQRT: begin
                  op_p0     = OP_SQRT;
                  rounds_p0 = 1'b1;
                  ok_p0     = (insn.rs2 == 5'd0);
               end
               F5_SGNJ: begin
                  // rm selects J / JN / JX
                  op_p0  = OP_SGNJ;
                  sub_p0 = insn.rm;
                  ok_p0  = (insn.rm <= 3'b010);
               end
               F5_MINMAX: begin
                  op_p0  = OP_MINMAX;
                  sub_p0 = insn.rm;
                  ok_p0  = (insn.rm == RM_FMIN) || (insn.rm == RM_FMAX);
               end
               F5_CMP: begin
                  // rm selects FLE (000) / FLT (001) / FEQ (010)
                  op_p0  = OP_CMP;
                  sub_p0 = insn.rm;
                  ok_p0  = (insn.rm <= 3'b010);
               end
               F5_CLASS: begin
                  op_p0 = OP_CLASS;
                  ok_p0 = (insn.rs2 == 5'd0) && (insn.rm == 3'b001);
               end
               default: ok_p0 = 1'b0;
            endcase
         end
`ifdef FPU_DECODE_FUSED_EN
         OPC_FMADD:  begin op_p0 = OP_MADD;  rounds_p0 = 1'b1; ok_p0 = 1'b1; end
         OPC_FMSUB:  begin op_p0 = OP_MSUB;  rounds_p0 = 1'b1; ok_p0 = 1'b1; end
         OPC_FNMADD: begin op_p0 = OP_NMADD; rounds_p0 = 1'b1; ok_p0 = 1'b1; end
         OPC_FNMSUB: begin op_p0 = OP_NMSUB; rounds_p0 = 1'b1; ok_p0 = 1'b1; end
`endif
         default: ok_p0 = 1'b0;
      endcase

      legal_p0 = ok_p0 && (insn.fmt == FMT_H) && !(rounds_p0 && rm_res_p0[3]);

      // Illegal entries keep only rd so the trap handler can still report it.
      dec_p0    = '0;
      dec_p0.rd = insn.rd;
      if (legal_p0) begin
         dec_p0.op  = op_p0;
         dec_p0.sub = sub_p0;
         dec_p0.rm  = rounds_p0 ? rm_res_p0[2:0] : 3'b000;
         dec_p0.a   = in_rs1_val[15:0];
         dec_p0.b   = in_rs2_val[15:0];
`ifdef FPU_DECODE_FUSED_EN
         dec_p0.c   = in_rs3_val[15:0];
`endif
      end else begin
         dec_p0.illegal = 1'b1;
      end
   end

`ifdef FPU_DECODE_FUSED_EN
   assign unused_bits = ^{in_rs1_val[31:16], in_rs2_val[31:16], in_rs3_val[31:16], insn.rs1};
`else
   assign unused_bits = ^{in_rs1_val[31:16], in_rs2_val[31:16], in_rs3_val, insn.rs1};
`endif

   // Not-full comes straight from the registered pointers, so a pop in the
   // same cycle never opens the input while the queue is full.
   assign in_ready = !fifo_full && !RST;
   assign vld_p0   = in_valid && in_ready;
   assign pop      = vld_p1 && out_ready;

   // ---- stage p1: queued entries, head presented to the execute stage ----
   fpu_dec_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (vld_p0),
      .push_data (dec_p0),
      .pop       (pop),
      .head      (head_bits_p1),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign vld_p1 = !fifo_empty;

   // Storage is not reset, so the data outputs are forced to 0 while empty.
   assign head_p1 = vld_p1 ? fpu_dec_entry_t'(head_bits_p1) : '0;

   assign out_valid   = vld_p1;
   assign out_op      = head_p1.op;
   assign out_sub     = head_p1.sub;
   assign out_rm      = head_p1.rm;
   assign out_a       = head_p1.a;
   assign out_b       = head_p1.b;
   assign out_c       = head_p1.c;
   assign out_rd      = head_p1.rd;
   assign out_illegal = head_p1.illegal;

endmodule

// File: tb/tb_fpu_insn_decoder.sv
module tb_fpu_insn_decoder;
   import fpu_types_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_insn;
   logic [31:0] in_rs1_val, in_rs2_val, in_rs3_val;
   logic        frm_we;
   logic [2:0]  frm_wdata;
   logic [2:0]  frm;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic [2:0]  out_sub, out_rm;
   logic [15:0] out_a, out_b, out_c;
   logic [4:0]  out_rd;
   logic        out_illegal;

   fpu_insn_decoder #(.DEPTH(2)) dut (
      .CLK(clk), .RST(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_rs3_val(in_rs3_val),
      .frm_we(frm_we), .frm_wdata(frm_wdata), .frm(frm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op(out_op), .out_sub(out_sub), .out_rm(out_rm),
      .out_a(out_a), .out_b(out_b), .out_c(out_c),
      .out_rd(out_rd), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   fpu_dec_entry_t exp_q[$];
   logic [2:0] model_frm;
   logic rand_mode = 1'b0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference decode, written from the instruction-set rules.
   function automatic fpu_dec_entry_t model(input logic [31:0] insn, input logic [31:0] rs1,
                                            input logic [31:0] rs2, input logic [31:0] rs3,
                                            input logic [2:0] dyn);
      fpu_dec_entry_t e;
      fpu_operation_t op;
      logic [6:0] opc;
      logic [4:0] f5, r2;
      logic [2:0] rm, sub, eff;
      logic legal, rounds, fused_en;
      opc = insn[6:0]; f5 = insn[31:27]; r2 = insn[24:20]; rm = insn[14:12];
      op = OP_NONE; sub = 3'd0; legal = 1'b0; rounds = 1'b0; eff = 3'd0;
`ifdef FPU_DECODE_FUSED_EN
      fused_en = 1'b1;
`else
      fused_en = 1'b0;
`endif
      if (opc == 7'b1010011) begin
         case (f5)
            5'd0:  begin op = OP_ADD;  rounds = 1'b1; legal = 1'b1; end
            5'd1:  begin op = OP_SUB;  rounds = 1'b1; legal = 1'b1; end
            5'd2:  begin op = OP_MUL;  rounds = 1'b1; legal = 1'b1; end
            5'd3:  begin op = OP_DIV;  rounds = 1'b1; legal = 1'b1; end
            5'd11: begin op = OP_SQRT; rounds = 1'b1; legal = (r2 == 0); end
            5'd4:  begin op = OP_SGNJ;   sub = rm; legal = (rm inside {3'd0, 3'd1, 3'd2}); end
            5'd5:  begin op = OP_MINMAX; sub = rm; legal = (rm inside {3'd0, 3'd1}); end
            5'd20: begin op = OP_CMP;    sub = rm; legal = (rm inside {3'd0, 3'd1, 3'd2}); end
            5'd28: begin op = OP_CLASS;  legal = (r2 == 0) && (rm == 3'd1); end
            default: legal = 1'b0;
         endcase
      end else if (fused_en && opc == 7'b1000011) begin op = OP_MADD;  rounds = 1'b1; legal = 1'b1; end
      else if (fused_en && opc == 7'b1000111) begin op = OP_MSUB;  rounds = 1'b1; legal = 1'b1; end
      else if (fused_en && opc == 7'b1001111) begin op = OP_NMADD; rounds = 1'b1; legal = 1'b1; end
      else if (fused_en && opc == 7'b1001011) begin op = OP_NMSUB; rounds = 1'b1; legal = 1'b1; end
      if (rounds) begin
         eff = (rm == 3'd7) ? dyn : rm;
         if (eff > 3'd4) legal = 1'b0;
      end
      if (insn[26:25] != 2'b10) legal = 1'b0;
      e = '0;
      e.rd = insn[11:7];
      if (legal) begin
         e.op = op; e.sub = sub; e.rm = rounds ? eff : 3'd0;
         e.a = rs1[15:0]; e.b = rs2[15:0];
         e.c = fused_en ? rs3[15:0] : 16'd0;
      end else begin
         e.illegal = 1'b1;
      end
      return e;
   endfunction

   always @(posedge clk) begin
      if (rst) model_frm <= 3'd0;
      else if (frm_we) model_frm <= frm_wdata;
   end

   // Expected-response producer: records every accepted instruction.
   always @(negedge clk) begin
      if (!rst && in_valid && in_ready)
         exp_q.push_back(model(in_insn, in_rs1_val, in_rs2_val, in_rs3_val, model_frm));
   end

   // Output monitor.
   fpu_dec_entry_t cur, held, expv;
   logic hold_pend = 1'b0;
   always @(negedge clk) begin
      cur = {out_op, out_sub, out_rm, out_a, out_b, out_c, out_rd, out_illegal};
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         check("frm", frm, model_frm);
         if (hold_pend) check("hold_stable", {out_valid, cur}, {1'b1, held});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_output: got %0h, required no output", cur);
            end else begin
               expv = exp_q.pop_front();
               check("entry", cur, expv);
            end
         end
         hold_pend = out_valid && !out_ready;
         held = cur;
      end
   end

   function automatic logic [31:0] mk_opfp(input logic [4:0] f5, input logic [1:0] fmt,
                                           input logic [4:0] r2, input logic [2:0] rm,
                                           input logic [4:0] rd);
      return {f5, fmt, r2, 5'd1, rm, rd, 7'b1010011};
   endfunction

   // Called at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic issue(input logic [31:0] insn, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] r3);
      logic acc;
      acc = 1'b0;
      in_insn = insn; in_rs1_val = r1; in_rs2_val = r2; in_rs3_val = r3;
      in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin acc = 1'b1; break; end
      end
      if (!acc) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
      check("drain", exp_q.size(), 0);
      #1;
   endtask

   function automatic logic [31:0] rand_insn();
      logic [31:0] r;
      logic [6:0] opc;
      logic [4:0] f5, r2;
      logic [1:0] fmt;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: opc = 7'b1000011;
         1: opc = 7'b1000111;
         2: opc = 7'b1001011;
         3: opc = 7'b1001111;
         4: opc = r[6:0];
         default: opc = 7'b1010011;
      endcase
      case ($urandom_range(0, 9))
         0: f5 = 5'd0;  1: f5 = 5'd1;  2: f5 = 5'd2;  3: f5 = 5'd3;
         4: f5 = 5'd11; 5: f5 = 5'd4;  6: f5 = 5'd5;  7: f5 = 5'd20;
         8: f5 = 5'd28; default: f5 = r[31:27];
      endcase
      fmt = ($urandom_range(0, 7) == 0) ? r[26:25] : 2'b10;
      r2  = ($urandom_range(0, 1) == 0) ? 5'd0 : r[24:20];
      return {f5, fmt, r2, r[19:15], r[14:12], r[11:7], opc};
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_insn = mk_opfp(5'd0, 2'b10, 5'd0, 3'd0, 5'd1);
      in_rs1_val = 32'h1234; in_rs2_val = 32'h5678; in_rs3_val = 32'h0;
      frm_we = 1'b0; frm_wdata = 3'd0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_frm", frm, 0);
      check("rst_out_data", {out_op, out_sub, out_rm, out_a, out_b, out_c, out_rd, out_illegal}, 0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1);
      @(posedge clk); #1;

      // FADD.H with dynamic rounding
      frm_we = 1'b1; frm_wdata = 3'b010;
      @(posedge clk); #1;
      frm_we = 1'b0;
      issue(mk_opfp(5'd0, 2'b10, 5'd2, 3'b111, 5'd3), 32'hDEAD3C00, 32'h00004000, 32'h0);
      @(negedge clk);
      check("fadd_valid", out_valid, 1);
      check("fadd_op", out_op, OP_ADD);
      check("fadd_rm", out_rm, 3'b010);
      check("fadd_a", out_a, 16'h3C00);
      check("fadd_b", out_b, 16'h4000);
      check("fadd_illegal", out_illegal, 0);
      @(posedge clk); #1;

      // frm write in the same cycle as a dynamic-rm decode
      frm_we = 1'b1; frm_wdata = 3'b101;
      issue(mk_opfp(5'd2, 2'b10, 5'd2, 3'b111, 5'd4), 32'h3C00, 32'h3C00, 32'h0);
      frm_we = 1'b0;
      @(negedge clk);
      check("fmul_old_frm_illegal", out_illegal, 0);
      check("fmul_old_frm_rm", out_rm, 3'b010);
      check("frm_written", frm, 3'b101);
      @(posedge clk); #1;
      issue(mk_opfp(5'd2, 2'b10, 5'd2, 3'b111, 5'd4), 32'h3C00, 32'h3C00, 32'h0);
      @(negedge clk);
      check("fmul_new_frm_illegal", out_illegal, 1);
      @(posedge clk); #1;

      // Illegal encodings
      issue(mk_opfp(5'd0, 2'b00, 5'd2, 3'b000, 5'd17), 32'h1111, 32'h2222, 32'h0);
      @(negedge clk);
      check("fmt00_ill", {out_illegal, out_op, out_rd, out_a}, {1'b1, 4'd0, 5'd17, 16'd0});
      @(posedge clk); #1;
      issue(mk_opfp(5'd28, 2'b10, 5'd3, 3'b001, 5'd18), 32'h1111, 32'h2222, 32'h0);
      @(negedge clk);
      check("fclass_rs2_ill", {out_illegal, out_op, out_rd}, {1'b1, 4'd0, 5'd18});
      @(posedge clk); #1;
      issue(mk_opfp(5'd20, 2'b10, 5'd2, 3'b011, 5'd19), 32'h1111, 32'h2222, 32'h0);
      @(negedge clk);
      check("cmp_rm011_ill", {out_illegal, out_op, out_rd}, {1'b1, 4'd0, 5'd19});
      @(posedge clk); #1;

      // FMADD
      issue({5'd7, 2'b10, 5'd2, 5'd1, 3'b000, 5'd9, 7'b1000011}, 32'h3C00, 32'h4000, 32'h00003800);
      @(negedge clk);
`ifdef FPU_DECODE_FUSED_EN
      check("fmadd_op", {out_illegal, out_op, out_c}, {1'b0, 4'(OP_MADD), 16'h3800});
`else
      check("fmadd_ill", {out_illegal, out_op, out_c}, {1'b1, 4'd0, 16'h0});
`endif
      @(posedge clk); #1;
      wait_drain();

      // Full FIFO: third push held off, no pass-through
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(mk_opfp(5'd1, 2'b10, 5'd2, 3'b000, 5'd21), 32'hA, 32'hB, 32'h0);
      issue(mk_opfp(5'd3, 2'b10, 5'd2, 3'b001, 5'd22), 32'hC, 32'hD, 32'h0);
      in_insn = mk_opfp(5'd5, 2'b10, 5'd2, 3'b001, 5'd23);
      in_rs1_val = 32'hE; in_rs2_val = 32'hF; in_valid = 1'b1;
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      check("full_head_rd", out_rd, 5'd21);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("full_no_passthru", in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("ready_after_pop", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_drain();

      // Reset mid-operation discards queued entries
      @(posedge clk); #1;
      frm_we = 1'b1; frm_wdata = 3'b011;
      @(posedge clk); #1;
      frm_we = 1'b0; out_ready = 1'b0;
      issue(mk_opfp(5'd0, 2'b10, 5'd2, 3'b000, 5'd5), 32'h1, 32'h2, 32'h0);
      issue(mk_opfp(5'd0, 2'b10, 5'd2, 3'b000, 5'd6), 32'h3, 32'h4, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_frm", frm, 0);
      @(posedge clk); #1;

      // Randomized traffic with random back-pressure and frm writes
      rand_mode = 1'b1;
      fork
         begin
            for (int n = 0; n < 600; n++)
               issue(rand_insn(), $urandom, $urandom, $urandom);
            rand_mode = 1'b0;
         end
         begin
            while (rand_mode) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
               frm_we    = ($urandom_range(0, 7) == 0);
               frm_wdata = 3'($urandom_range(0, 7));
            end
            out_ready = 1'b1;
            frm_we = 1'b0;
         end
      join
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
